sensor_alarm_fsm_n: RTL and testbench
=====================================

Name: sensor_alarm_fsm_n

Overview:
- Parametrised successor of the single-channel temperature/gas alarm controller.
- Takes NCH sensor channels of DW bits and computes the hottest channel each sample.
- Runs a 3-level alarm FSM (normal/alerta/peligro) with a persistence filter, hysteresis and an operator-acknowledge latch.
- Sits between the sample front end (keyboard/ADC decode) and the Temps/Gas/Alerta/Peligro indicator outputs of the top level.

Parameters:
- NCH, 4, number of sensor channels (1..16).
- DW, 4, bits per sample.
- PERSIST, 3, consecutive valid samples needed to change state (1..255).
- HYST, 1, hysteresis subtracted from a threshold on falling transitions.

Ports:
- CLK_G  in  1  system clock.
- reset_G  in  1  asynchronous active-low reset.
- smp_valid  in  1  one-cycle strobe; smp_data is valid.
- smp_data  in  NCH*DW  packed samples; channel k at bits [k*DW +: DW].
- thr_alert  in  DW  alert threshold.
- thr_danger  in  DW  danger threshold.
- ack  in  1  operator acknowledge (level, sampled each cycle).
- temp_max  out  DW  registered maximum sample.
- ch_max_idx  out  clog2(NCH) (min 1)  index of the maximum channel.
- state  out  2  00 NORMAL, 01 ALERT, 10 DANGER.
- gas  out  1  extractor on.
- alerta  out  1  alert indicator.
- peligro  out  1  danger indicator.
- fsm_clr  out  1  one-cycle pulse on entry to NORMAL.

Behaviour:
- Reset (async, reset_G=0): state=NORMAL; temp_max=0, ch_max_idx=0, persistence count=0; gas, alerta, peligro and fsm_clr all 0. Takes effect mid-operation with no completion of the pending sample.
- Stage 1: on smp_valid at edge t, temp_max/ch_max_idx update at t+1.
  - Ties go to the lowest index. Unsigned compare.
  - A valid1 flag is registered alongside.
- Stage 2 (FSM) evaluates on valid1.
  - State and outputs change at edge t+2.
  - gas = state is ALERT or DANGER; alerta = ALERT; peligro = DANGER. All outputs come straight from registers.
- Effective thresholds:
  - TA = thr_alert.
  - TD = max(thr_alert, thr_danger).
  - Falling levels TA_lo = TA - HYST and TD_lo = TD - HYST, both saturating at 0.
- Persistence counter:
  - Increments on valid1 while the state's pending condition holds.
  - Clears when the condition fails on a valid sample, and on any state change.
  - Saturates at PERSIST.
  - Transition fires on the valid1 where count+1 == PERSIST.
  - Non-valid cycles neither count nor clear.
- NORMAL:
  - Condition temp_max >= TA; PERSIST hits -> ALERT.
  - temp_max >= TD also counts toward ALERT, never a direct jump to DANGER.
- ALERT:
  - Rising condition temp_max >= TD; PERSIST hits -> DANGER.
  - Falling condition temp_max < TA_lo; PERSIST hits -> NORMAL.
  - One counter is used: when the condition type changes, the count restarts at 1. Samples in [TA_lo, TD) clear it.
- DANGER is latching.
  - Leaves only to ALERT, on a cycle with ack=1 AND the most recent temp_max < TD_lo.
  - No persistence is required on exit.
  - ack in NORMAL or ALERT is ignored.
  - ack on the same edge as a valid1 with temp_max >= TD_lo: the check uses the new temp_max, so the FSM stays in DANGER.
- fsm_clr pulses for exactly 1 cycle on each ALERT->NORMAL transition. It does not pulse on reset release.
- thr_* may change at any time and are used combinationally at evaluation.

Decomposition:
- Shared package alarm_pkg holds:
  - State encodings ST_NORMAL/ST_ALERT/ST_DANGER.
  - Default PERSIST/HYST constants.
  - A saturating-subtract function.
- One sub-module, max_tree_n: parametrised NCH x DW maximum with index and lowest-index tie-break.
  - Purely combinational; registered by the parent.

Test Plan (NCH=4, DW=4, PERSIST=3, HYST=1, thr_alert=8, thr_danger=12):
- Samples {3,9,2,1} x3 strobes -> temp_max=9, ch_max_idx=1; state=ALERT, alerta=1, gas=1, two cycles after the 3rd strobe; after only 2 strobes, still NORMAL.
- Reach ALERT, then samples with max 13 x3 -> DANGER, peligro=1. Then max 5, ack=0 -> stays DANGER. Then ack=1 -> ALERT next edge.
- In ALERT, sample max sequence 6,6,8,6,6,6 -> NORMAL only after the 6th sample; fsm_clr high exactly 1 cycle; 8 is in [TA_lo=7, TD) and clears the count.
- Ties: {12,12,0,12} -> ch_max_idx=0. Set thr_danger=5 with thr_alert=8 -> TD=8, so a max of 8 x3 in ALERT -> DANGER.
- In DANGER, ack=1 coincident with a valid max=11 (TD_lo=11) -> remains DANGER.
- Assert reset_G=0 mid-stream between edges -> all outputs 0 immediately (async), state NORMAL; after release, the first 2 valid samples >=8 do not trigger ALERT.

Source files
------------

// File: rtl/sensor_alarm_fsm_n_pkg.sv
// Shared definitions for the multi-channel sensor alarm controller:
// state encodings, default filter constants and a saturating subtract.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_ALERT  = 2'b01,
        ST_DANGER = 2'b10
    } alarm_state_t;

    typedef enum logic {
        DIR_RISE = 1'b0,
        DIR_FALL = 1'b1
    } cnt_dir_t;

    localparam int DEF_PERSIST = 3;
    localparam int DEF_HYST    = 1;

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/sensor_alarm_fsm_n_max_tree.sv
// Combinational maximum over NCH packed unsigned samples; on equal values
// the lowest channel index wins.
module max_tree_n #(
    parameter int NCH = 4,
    parameter int DW  = 4,
    parameter int IW  = 2
) (
    input  logic [NCH*DW-1:0] data,
    output logic [DW-1:0]     max_val,
    output logic [IW-1:0]     max_idx
);

    // Strict greater-than keeps the earlier channel on ties.
    always_comb begin
        max_val = data[DW-1:0];
        max_idx = '0;
        for (int k = 1; k < NCH; k++) begin
            if (data[k*DW +: DW] > max_val) begin
                max_val = data[k*DW +: DW];
                max_idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/sensor_alarm_fsm_n.sv
// Multi-channel temperature/gas alarm: registers the hottest channel each
// sample, then runs a filtered NORMAL/ALERT/DANGER FSM with hysteresis and ack.
module sensor_alarm_fsm_n
    import alarm_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 4,
    parameter int PERSIST = DEF_PERSIST,
    parameter int HYST    = DEF_HYST,
    localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK_G,
    input  logic              reset_G,
    input  logic              smp_valid,
    input  logic [NCH*DW-1:0] smp_data,
    input  logic [DW-1:0]     thr_alert,
    input  logic [DW-1:0]     thr_danger,
    input  logic              ack,
    output logic [DW-1:0]     temp_max,
    output logic [IW-1:0]     ch_max_idx,
    output logic [1:0]        state,
    output logic              gas,
    output logic              alerta,
    output logic              peligro,
    output logic              fsm_clr
);

    localparam logic [7:0] PERSIST_C = 8'(PERSIST);

    logic [DW-1:0] max_val;
    logic [IW-1:0] max_idx;
    logic          valid1;

    logic [DW-1:0] ta, td, ta_lo, td_lo;

    alarm_state_t state_q, state_d, tgt_state;
    cnt_dir_t     dir_q, dir_d, want_dir;
    logic [7:0]   cnt_q, cnt_d, cnt_inc;
    logic         cond;

    max_tree_n #(
        .NCH (NCH),
        .DW  (DW),
        .IW  (IW)
    ) u_max (
        .data    (smp_data),
        .max_val (max_val),
        .max_idx (max_idx)
    );

    always_ff @(posedge CLK_G or negedge reset_G) begin
        if (!reset_G) begin
            temp_max   <= '0;
            ch_max_idx <= '0;
            valid1     <= 1'b0;
        end else begin
            valid1 <= smp_valid;
            if (smp_valid) begin
                temp_max   <= max_val;
                ch_max_idx <= max_idx;
            end
        end
    end

    // Danger threshold never sits below alert; falling levels saturate at 0.
    always_comb begin
        ta    = thr_alert;
        td    = (thr_danger > thr_alert) ? thr_danger : thr_alert;
        ta_lo = DW'(sat_sub(32'(ta), 32'(HYST)));
        td_lo = DW'(sat_sub(32'(td), 32'(HYST)));
    end

    // One persistence counter; a change of condition direction restarts it at 1.
    always_comb begin
        cond      = 1'b0;
        want_dir  = DIR_RISE;
        tgt_state = state_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;

        case (state_q)
            ST_NORMAL: begin
                cond      = (temp_max >= ta);
                want_dir  = DIR_RISE;
                tgt_state = ST_ALERT;
            end
            ST_ALERT: begin
                if (temp_max >= td) begin
                    cond      = 1'b1;
                    want_dir  = DIR_RISE;
                    tgt_state = ST_DANGER;
                end else if (temp_max < ta_lo) begin
                    cond      = 1'b1;
                    want_dir  = DIR_FALL;
                    tgt_state = ST_NORMAL;
                end
            end
            default: ;
        endcase

        cnt_inc = (cnt_q != 8'd0 && dir_q == want_dir) ? cnt_q + 8'd1 : 8'd1;

        case (state_q)
            ST_NORMAL, ST_ALERT: begin
                if (valid1) begin
                    if (cond) begin
                        if (cnt_inc >= PERSIST_C) begin
                            state_d = tgt_state;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_inc;
                            dir_d = want_dir;
                        end
                    end else begin
                        cnt_d = 8'd0;
                    end
                end
            end
            ST_DANGER: begin
                cnt_d = 8'd0;
                if (ack && temp_max < td_lo) begin
                    state_d = ST_ALERT;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK_G or negedge reset_G) begin
        if (!reset_G) begin
            state_q <= ST_NORMAL;
            cnt_q   <= 8'd0;
            dir_q   <= DIR_RISE;
            gas     <= 1'b0;
            alerta  <= 1'b0;
            peligro <= 1'b0;
            fsm_clr <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            gas     <= (state_d == ST_ALERT) || (state_d == ST_DANGER);
            alerta  <= (state_d == ST_ALERT);
            peligro <= (state_d == ST_DANGER);
            fsm_clr <= (state_q == ST_ALERT) && (state_d == ST_NORMAL);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_sensor_alarm_fsm_n.sv
// Directed bench for sensor_alarm_fsm_n with NCH=4, DW=4, PERSIST=3, HYST=1.
module tb_sensor_alarm_fsm_n;

    logic        CLK_G = 1'b0;
    logic        reset_G;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic [3:0]  thr_alert;
    logic [3:0]  thr_danger;
    logic        ack;
    logic [3:0]  temp_max;
    logic [1:0]  ch_max_idx;
    logic [1:0]  state;
    logic        gas, alerta, peligro, fsm_clr;

    int checks = 0;
    int errors = 0;

    sensor_alarm_fsm_n #(
        .NCH     (4),
        .DW      (4),
        .PERSIST (3),
        .HYST    (1)
    ) dut (
        .CLK_G      (CLK_G),
        .reset_G    (reset_G),
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .thr_alert  (thr_alert),
        .thr_danger (thr_danger),
        .ack        (ack),
        .temp_max   (temp_max),
        .ch_max_idx (ch_max_idx),
        .state      (state),
        .gas        (gas),
        .alerta     (alerta),
        .peligro    (peligro),
        .fsm_clr    (fsm_clr)
    );

    always #5 CLK_G = ~CLK_G;

    function automatic logic [15:0] pk(input logic [3:0] c0, input logic [3:0] c1,
                                       input logic [3:0] c2, input logic [3:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_G);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] data);
        smp_data  = data;
        smp_valid = 1'b1;
        tick();
        smp_valid = 1'b0;
    endtask

    task automatic sendSettle(input logic [15:0] data);
        applyStimulus(data);
        tick();
    endtask

    initial begin
        reset_G    = 1'b0;
        smp_valid  = 1'b0;
        smp_data   = '0;
        thr_alert  = 4'd8;
        thr_danger = 4'd12;
        ack        = 1'b0;

        #2;
        checkOutput("rst_state", 32'(state), 0);
        checkOutput("rst_temp", 32'(temp_max), 0);
        checkOutput("rst_idx", 32'(ch_max_idx), 0);
        checkOutput("rst_gas", 32'(gas), 0);
        checkOutput("rst_clr", 32'(fsm_clr), 0);
        #11 reset_G = 1'b1;
        tick();
        checkOutput("rel_clr", 32'(fsm_clr), 0);

        // Three strobes needed before ALERT, two-edge latency to the state.
        sendSettle(pk(3, 9, 2, 1));
        sendSettle(pk(3, 9, 2, 1));
        checkOutput("two_strobes_state", 32'(state), 0);
        checkOutput("max_val", 32'(temp_max), 9);
        checkOutput("max_idx", 32'(ch_max_idx), 1);
        applyStimulus(pk(3, 9, 2, 1));
        checkOutput("latency_state", 32'(state), 0);
        tick();
        checkOutput("alert_state", 32'(state), 1);
        checkOutput("alert_alerta", 32'(alerta), 1);
        checkOutput("alert_gas", 32'(gas), 1);
        checkOutput("alert_peligro", 32'(peligro), 0);

        // ALERT -> DANGER, latch, then ack exit.
        sendSettle(pk(0, 13, 0, 0));
        sendSettle(pk(0, 13, 0, 0));
        checkOutput("pre_danger", 32'(state), 1);
        sendSettle(pk(0, 13, 0, 0));
        checkOutput("danger_state", 32'(state), 2);
        checkOutput("danger_peligro", 32'(peligro), 1);
        checkOutput("danger_gas", 32'(gas), 1);
        checkOutput("danger_alerta", 32'(alerta), 0);
        sendSettle(pk(5, 0, 0, 0));
        tick();
        tick();
        checkOutput("danger_latch", 32'(state), 2);
        ack = 1'b1;
        tick();
        checkOutput("ack_exit", 32'(state), 1);
        ack = 1'b0;

        // Falling path with a mid-band sample clearing the count.
        sendSettle(pk(6, 0, 0, 0));
        sendSettle(pk(6, 0, 0, 0));
        sendSettle(pk(0, 8, 0, 0));
        sendSettle(pk(6, 0, 0, 0));
        sendSettle(pk(6, 0, 0, 0));
        checkOutput("fall_5th", 32'(state), 1);
        checkOutput("fall_5th_clr", 32'(fsm_clr), 0);
        sendSettle(pk(6, 0, 0, 0));
        checkOutput("fall_normal", 32'(state), 0);
        checkOutput("clr_pulse", 32'(fsm_clr), 1);
        checkOutput("normal_gas", 32'(gas), 0);
        tick();
        checkOutput("clr_one_cycle", 32'(fsm_clr), 0);

        // Tie-break and danger threshold clamped up to alert.
        sendSettle(pk(12, 12, 0, 12));
        checkOutput("tie_idx", 32'(ch_max_idx), 0);
        checkOutput("tie_val", 32'(temp_max), 12);
        thr_danger = 4'd5;
        sendSettle(pk(0, 0, 8, 0));
        checkOutput("idx2", 32'(ch_max_idx), 2);
        checkOutput("norm_cnt2", 32'(state), 0);
        sendSettle(pk(0, 0, 8, 0));
        checkOutput("td_alert", 32'(state), 1);
        sendSettle(pk(0, 0, 8, 0));
        sendSettle(pk(0, 0, 8, 0));
        checkOutput("td_pre", 32'(state), 1);
        sendSettle(pk(0, 0, 8, 0));
        checkOutput("td_danger", 32'(state), 2);

        // Ack coincident with a valid sample at TD_lo keeps DANGER.
        thr_danger = 4'd12;
        applyStimulus(pk(0, 11, 0, 0));
        ack = 1'b1;
        tick();
        checkOutput("ack_tdlo", 32'(state), 2);
        tick();
        checkOutput("ack_tdlo_hold", 32'(state), 2);
        sendSettle(pk(10, 0, 0, 0));
        checkOutput("ack_below", 32'(state), 1);
        ack = 1'b0;

        // Asynchronous reset between edges.
        smp_data  = pk(9, 9, 9, 9);
        smp_valid = 1'b1;
        #2 reset_G = 1'b0;
        #1;
        checkOutput("arst_state", 32'(state), 0);
        checkOutput("arst_temp", 32'(temp_max), 0);
        checkOutput("arst_idx", 32'(ch_max_idx), 0);
        checkOutput("arst_alerta", 32'(alerta), 0);
        checkOutput("arst_gas", 32'(gas), 0);
        checkOutput("arst_peligro", 32'(peligro), 0);
        smp_valid = 1'b0;
        @(negedge CLK_G);
        reset_G = 1'b1;
        tick();
        checkOutput("arel_clr", 32'(fsm_clr), 0);
        sendSettle(pk(9, 0, 0, 0));
        sendSettle(pk(9, 0, 0, 0));
        checkOutput("arel_two", 32'(state), 0);
        sendSettle(pk(9, 0, 0, 0));
        checkOutput("arel_three", 32'(state), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
